maze_stim_checker: RTL and testbench
====================================

# maze_stim_checker

Counterpart of the maze path-finder block. Serially transmits a stored 17x17 maze, one bit per cycle, into the path-finder's `in_valid`/`in` input. It then consumes the returned `out_valid`/`out` direction stream and replays each step on the stored maze to judge the path legal. It sits beside the path-finder in the lab top/bench as a reusable driver-plus-scoreboard.

## Interface
Parameters:
- MAZE_WIDTH, 17, maze side length (cells per row/column).
- TIMEOUT, 3000, max cycles in WAIT before `path_valid` must rise.
- MAX_STEPS, 289, max accepted path length.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  row write strobe; ignored while busy.
- cfg_row  in  5  row index 0..16 written by cfg_we; values >16 ignored.
- cfg_data  in  17  row contents, bit j = cell (row, j); 1 = path, 0 = wall.
- start  in  1  one-cycle pulse to begin a run; ignored while busy.
- maze_valid  out  1  drives path-finder `in_valid`.
- maze_bit  out  1  drives path-finder `in`.
- path_valid  in  1  from path-finder `out_valid`.
- path_dir  in  2  from path-finder `out`: 0 RIGHT (y+1), 1 DOWN (x+1), 2 LEFT (y-1), 3 UP (x-1).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result, valid from done until next start.
- err_code  out  3  0 none, 1 wall, 2 out-of-bounds, 3 wrong end cell, 4 timeout, 5 protocol, 6 overlength.
- step_cnt  out  9  directions consumed in current run.

## Operation
- Storage: 17 x 17-bit row registers, cleared to 0 on reset; written only in IDLE.
- States: IDLE, SEND, WAIT, CHECK, DONE.
- IDLE: on start go to SEND; clear step_cnt, err_code, pass; cursor (r,c)=(0,0).
- SEND: output cell (r,c) row-major, c increments fastest (matches path-finder load order x=row, y=column). After cell (16,16) go to WAIT. Exactly 289 maze_valid cycles, no gaps.
- WAIT: position (x,y)=(0,0), timeout counter runs. path_valid=1 -> CHECK, processing that cycle's direction. Counter reaching TIMEOUT -> err 4, DONE.
- CHECK: each cycle with path_valid=1: step_cnt+1. If no error latched, compute next cell. Bounds are checked before moving (RIGHT at y=16, DOWN at x=16, LEFT at y=0, UP at x=0 -> err 2). Otherwise move; if the new cell is 0 -> err 1. step_cnt reaching MAX_STEPS+1 -> err 6.
- First error is latched; later steps only count, with no further checks.
- path_valid falling -> DONE. If no error is latched and (x,y)!=(16,16) -> err 3.
- DONE: one cycle; done=1; pass=(err_code==0); return to IDLE.
- Protocol: path_valid=1 during SEND -> err 5 latched; SEND still completes, then WAIT/CHECK proceed normally.
- Arithmetic: x,y are 5-bit unsigned. The bounds check prevents wrap. step_cnt saturates at 511.

## Timing
- Reset values: maze_valid 0, maze_bit 0, busy 0, done 0, pass 0, err_code 0, step_cnt 0; state IDLE.
- Reset mid-run aborts immediately to IDLE with the stored maze cleared.
- start sampled at cycle T -> maze_valid=1 with cell (0,0) at T+1; last cell at T+289; maze_valid=0 at T+290.
- maze_valid and maze_bit are registered outputs.
- Direction sampled in cycle N updates err_code/step_cnt at N+1.
- First cycle with path_valid=0 after the stream is N -> done=1 at N+1, busy=0 at N+2.
- start in the same cycle as done is ignored; start in IDLE is accepted the next cycle.
- A zero-length path cannot occur, because WAIT only exits on path_valid=1 or timeout.

## Test plan
- Straight-L maze (row 0 and column 16 all 1, rest 0); path 16x RIGHT then 16x DOWN -> 289 maze_valid cycles in correct order; done with pass=1, err_code=0, step_cnt=32.
- Same maze; path RIGHT then DOWN at (0,1) -> err_code=1, pass=0, step_cnt counts all returned steps.
- Path beginning with UP -> err_code=2.
- Legal path stopping at (0,16) -> err_code=3.
- No path_valid for 3000 cycles after SEND -> done with err_code=4, step_cnt=0.
- path_valid pulsed during SEND -> err_code=5. Separately, assert rst_n low at SEND cycle 100 -> all outputs at reset values, maze cleared, a new start transmits all zeros.

Source files
------------

// File: rtl/maze_stim_if.sv
// Link between the maze stimulus/checker and the path-finder.
//   maze_valid/maze_bit : serial maze stream toward the path-finder (in_valid/in)
//   path_valid/path_dir : direction stream back from the path-finder (out_valid/out)
// master = checker side, slave = path-finder side.
interface maze_stim_if;
  logic       maze_valid;
  logic       maze_bit;
  logic       path_valid;
  logic [1:0] path_dir;

  modport master (output maze_valid, maze_bit, input  path_valid, path_dir);
  modport slave  (input  maze_valid, maze_bit, output path_valid, path_dir);
endinterface

// File: rtl/maze_stim_checker.sv
// Maze driver plus path scoreboard.
// The stored maze is sent serially, row-major, to a path-finder. The returned
// direction stream is then replayed on the stored maze, and the path is
// judged legal or not.
//   clk, rst_n            : clock; asynchronous active-low reset
//   cfg_we/cfg_row/cfg_data : maze row writes, accepted only while idle
//   start                 : begins a run
//   pf (master)           : maze stream out, direction stream in
//   busy, done, pass      : run status; pass holds from done until the next start
//   err_code, step_cnt    : first error seen, and count of directions consumed
module maze_stim_checker #(
  parameter int MAZE_WIDTH = 17,
  parameter int TIMEOUT    = 3000,
  parameter int MAX_STEPS  = 289
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_row,
  input  logic [MAZE_WIDTH-1:0] cfg_data,
  input  logic                  start,
  maze_stim_if.master           pf,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            err_code,
  output logic [8:0]            step_cnt
);
  localparam logic [4:0] LAST = 5'(MAZE_WIDTH - 1);
  localparam int         TW   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ERR_NONE = 3'd0, ERR_WALL = 3'd1, ERR_OOB  = 3'd2,
                         ERR_END  = 3'd3, ERR_TO   = 3'd4, ERR_PROT = 3'd5,
                         ERR_LEN  = 3'd6;
  localparam logic [1:0] DIR_R = 2'd0, DIR_D = 2'd1, DIR_L = 2'd2, DIR_U = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [MAZE_WIDTH-1:0] rows_q [MAZE_WIDTH];
  logic [MAZE_WIDTH-1:0] rows_d [MAZE_WIDTH];
  logic [4:0]            r_q, r_d, c_q, c_d;   // next cell to send
  logic [4:0]            x_q, x_d, y_q, y_d;   // replay position
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [2:0]            err_q, err_d;
  logic [8:0]            step_q, step_d;
  logic                  pass_q, pass_d;
  logic                  mv_q, mv_d, mb_q, mb_d;
  logic                  take_step, oob;
  logic [4:0]            nx, ny;

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    r_d       = r_q;
    c_d       = c_q;
    x_d       = x_q;
    y_d       = y_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    step_d    = step_q;
    pass_d    = pass_q;
    mv_d      = 1'b0;
    mb_d      = 1'b0;
    take_step = 1'b0;
    oob       = 1'b0;
    nx        = x_q;
    ny        = y_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we && cfg_row <= LAST) rows_d[cfg_row] = cfg_data;
        if (start) begin
          // Cell (0,0) goes out on the very next cycle, so it is issued here.
          state_d = S_SEND;
          mv_d    = 1'b1;
          mb_d    = rows_q[0][0];
          r_d     = '0;
          c_d     = 5'd1;
          step_d  = '0;
          err_d   = ERR_NONE;
          pass_d  = 1'b0;
        end
      end
      S_SEND: begin
        if (pf.path_valid && err_q == ERR_NONE) err_d = ERR_PROT;
        if (r_q > LAST) begin
          // Every cell has been issued; maze_valid drops with this edge.
          state_d = S_WAIT;
          x_d     = '0;
          y_d     = '0;
          tcnt_d  = '0;
        end else begin
          mv_d = 1'b1;
          mb_d = rows_q[r_q][c_q];
          if (c_q == LAST) begin
            c_d = '0;
            r_d = r_q + 5'd1;
          end else begin
            c_d = c_q + 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (pf.path_valid) begin
          take_step = 1'b1;
          state_d   = S_CHECK;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          if (err_q == ERR_NONE) err_d = ERR_TO;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (pf.path_valid) begin
          take_step = 1'b1;
        end else begin
          if (err_q == ERR_NONE && !(x_q == LAST && y_q == LAST)) err_d = ERR_END;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (take_step) begin
      step_d = (step_q == 9'h1FF) ? step_q : step_q + 9'd1;
      // Once an error is latched the remaining steps are only counted.
      if (err_q == ERR_NONE) begin
        case (pf.path_dir)
          DIR_R:   if (y_q == LAST) oob = 1'b1; else ny = y_q + 5'd1;
          DIR_D:   if (x_q == LAST) oob = 1'b1; else nx = x_q + 5'd1;
          DIR_L:   if (y_q == '0)   oob = 1'b1; else ny = y_q - 5'd1;
          default: if (x_q == '0)   oob = 1'b1; else nx = x_q - 5'd1;
        endcase
        if (oob) begin
          err_d = ERR_OOB;
        end else begin
          x_d = nx;
          y_d = ny;
          if (!rows_q[nx][ny])              err_d = ERR_WALL;
          else if (step_d > 9'(MAX_STEPS))  err_d = ERR_LEN;
        end
      end
    end

    if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == ERR_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < MAZE_WIDTH; i++) rows_q[i] <= '0;
      r_q    <= '0;
      c_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      tcnt_q <= '0;
      err_q  <= ERR_NONE;
      step_q <= '0;
      pass_q <= 1'b0;
      mv_q   <= 1'b0;
      mb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      r_q     <= r_d;
      c_q     <= c_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      mv_q    <= mv_d;
      mb_q    <= mb_d;
    end
  end

  assign pf.maze_valid = mv_q;
  assign pf.maze_bit   = mb_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign err_code      = err_q;
  assign step_cnt      = step_q;
endmodule

// File: tb/tb_maze_stim_checker.sv
// Self-checking bench for maze_stim_checker: a table of directed runs, a
// reset-abort sequence, and randomized mazes/paths judged by a coordinate
// walking reference model.
module tb_maze_stim_checker;
  localparam int TIMEOUT = 3000;
  localparam logic [1:0] R = 2'd0, D = 2'd1, L = 2'd2, U = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_row = '0;
  logic [16:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [2:0]  err_code;
  logic [8:0]  step_cnt;

  maze_stim_if pf ();

  maze_stim_checker #(.MAZE_WIDTH(17), .TIMEOUT(TIMEOUT), .MAX_STEPS(289)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .start(start), .pf(pf), .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .step_cnt(step_cnt));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] maze_m [17];
  logic [1:0]  path_q [$];

  typedef struct {
    bit         full;     // 1: all-open maze, 0: L-shaped maze
    bit         pv_send;  // pulse path_valid during SEND
    int         reps;     // leading RIGHT,LEFT pairs
    logic [1:0] d0; int n0;
    logic [1:0] d1; int n1;
    logic [2:0] exp_e;
    int         exp_s;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic load_maze();
    for (int i = 0; i < 17; i++) begin
      cfg_we = 1'b1; cfg_row = 5'(i); cfg_data = maze_m[i];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic set_maze(input bit full);
    for (int i = 0; i < 17; i++)
      maze_m[i] = (full || i == 0) ? 17'h1FFFF : 17'h10000;
  endtask

  // Reference: walk the path on signed coordinates, first error wins.
  task automatic model(input bit pv_send, output logic [2:0] e, output int s);
    int x, y;
    x = 0; y = 0; s = 0;
    e = pv_send ? 3'd5 : 3'd0;
    if (path_q.size() == 0) begin
      if (e == 0) e = 3'd4;
      return;
    end
    foreach (path_q[i]) begin
      int nx, ny;
      nx = x; ny = y;
      s = (s < 511) ? s + 1 : 511;
      if (e != 0) continue;
      case (path_q[i])
        R: ny = y + 1;
        D: nx = x + 1;
        L: ny = y - 1;
        default: nx = x - 1;
      endcase
      if (nx < 0 || nx > 16 || ny < 0 || ny > 16) e = 3'd2;
      else begin
        x = nx; y = ny;
        if (maze_m[x][y] == 1'b0) e = 3'd1;
        else if (s > 289)         e = 3'd6;
      end
    end
    if (e == 0 && !(x == 16 && y == 16)) e = 3'd3;
  endtask

  task automatic run_case(input string nm, input bit pv_send, input logic [2:0] exp_e, input int exp_s);
    int nbad, n;
    chk({nm, " idle_mv"}, 32'(pf.maze_valid), 0);
    start = 1'b1; tick(); start = 1'b0;
    nbad = 0;
    for (int k = 0; k < 289; k++) begin
      if (pf.maze_valid !== 1'b1 || pf.maze_bit !== maze_m[k / 17][k % 17]) nbad++;
      pf.path_valid = pv_send && (k == 100);
      tick();
    end
    pf.path_valid = 1'b0;
    chk({nm, " stream_bad"}, nbad, 0);
    chk({nm, " mv_drop"}, 32'(pf.maze_valid), 0);
    chk({nm, " busy_wait"}, 32'(busy), 1);
    foreach (path_q[i]) begin
      pf.path_valid = 1'b1; pf.path_dir = path_q[i];
      tick();
    end
    pf.path_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < TIMEOUT + 10) begin
      tick(); n++;
    end
    chk({nm, " done_lat"}, n, (path_q.size() == 0) ? TIMEOUT : 1);
    chk({nm, " err"}, 32'(err_code), 32'(exp_e));
    chk({nm, " steps"}, 32'(step_cnt), exp_s);
    chk({nm, " pass"}, 32'(pass), (exp_e == 0) ? 1 : 0);
    tick();
    chk({nm, " busy_end"}, 32'(busy), 0);
    chk({nm, " done_end"}, 32'(done), 0);
  endtask

  vec_t tbl [12];

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] me;
    int ms;
    pf.path_valid = 1'b0;
    pf.path_dir   = 2'd0;

    tbl[0]  = '{0, 0, 0,   R, 16, D, 16, 3'd0, 32};
    tbl[1]  = '{0, 0, 0,   R, 1,  D, 5,  3'd1, 6};
    tbl[2]  = '{0, 0, 0,   U, 1,  R, 3,  3'd2, 4};
    tbl[3]  = '{0, 0, 0,   R, 16, D, 0,  3'd3, 16};
    tbl[4]  = '{0, 0, 0,   R, 0,  D, 0,  3'd4, 0};
    tbl[5]  = '{0, 1, 0,   R, 16, D, 16, 3'd5, 32};
    tbl[6]  = '{1, 0, 0,   R, 17, D, 0,  3'd2, 17};
    tbl[7]  = '{1, 0, 128, R, 16, D, 16, 3'd0, 288};
    tbl[8]  = '{1, 0, 129, R, 16, D, 16, 3'd6, 290};
    tbl[9]  = '{1, 0, 300, R, 0,  D, 0,  3'd6, 511};
    tbl[10] = '{1, 0, 0,   D, 16, L, 1,  3'd2, 17};
    tbl[11] = '{0, 0, 0,   D, 1,  R, 0,  3'd1, 1};

    repeat (3) tick();
    chk("rst mv", 32'(pf.maze_valid), 0);
    chk("rst mb", 32'(pf.maze_bit), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst pass", 32'(pass), 0);
    chk("rst err", 32'(err_code), 0);
    chk("rst steps", 32'(step_cnt), 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[t]) begin
      set_maze(tbl[t].full);
      load_maze();
      path_q.delete();
      for (int i = 0; i < tbl[t].reps; i++) begin path_q.push_back(R); path_q.push_back(L); end
      for (int i = 0; i < tbl[t].n0; i++) path_q.push_back(tbl[t].d0);
      for (int i = 0; i < tbl[t].n1; i++) path_q.push_back(tbl[t].d1);
      run_case($sformatf("vec%0d", t), tbl[t].pv_send, tbl[t].exp_e, tbl[t].exp_s);
    end

    // Reset in the middle of SEND: everything back to reset values, maze cleared.
    set_maze(1'b0);
    load_maze();
    start = 1'b1; tick(); start = 1'b0;
    repeat (99) tick();
    rst_n = 1'b0; #1;
    chk("midrst mv", 32'(pf.maze_valid), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst err", 32'(err_code), 0);
    chk("midrst steps", 32'(step_cnt), 0);
    tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 17; i++) maze_m[i] = '0;
    path_q.delete(); path_q.push_back(R);
    run_case("postrst", 1'b0, 3'd1, 1);

    // Random shuffles of 16 RIGHT / 16 DOWN on an open maze always succeed.
    for (int it = 0; it < 3; it++) begin
      int nr, nd;
      set_maze(1'b1); load_maze();
      path_q.delete(); nr = 16; nd = 16;
      while (nr + nd > 0) begin
        if (nd == 0 || (nr > 0 && $urandom_range(0, 1) == 0)) begin path_q.push_back(R); nr--; end
        else begin path_q.push_back(D); nd--; end
      end
      model(1'b0, me, ms);
      run_case($sformatf("shuf%0d", it), 1'b0, me, ms);
    end

    // Random dense mazes with random, mostly right/down paths.
    for (int it = 0; it < 8; it++) begin
      bit pv;
      int len;
      for (int i = 0; i < 17; i++) maze_m[i] = 17'($urandom | $urandom | $urandom);
      load_maze();
      path_q.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 9);
        path_q.push_back(r < 4 ? R : r < 8 ? D : r == 8 ? L : U);
      end
      pv = ($urandom_range(0, 5) == 0);
      model(pv, me, ms);
      run_case($sformatf("rand%0d", it), pv, me, ms);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
